// File: rtl/fifo_ctrl8.sv
// -----------------------------------------------------------------------------
// fifo_ctrl8 -- control block for an 8-entry FIFO built around an external
// register file. This block keeps the read/write pointers, the occupancy count
// and the status flags; it carries no data itself.
//
// Parameters
//   DW      data width of the attached register file (documentation only)
//   AF_LVL  almost-full threshold in entries, 1..8
//
// Ports
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   push_i    write request (data goes to the register file in the same cycle)
//   pop_i     read request (head entry consumed at this edge)
//   flush_i   synchronous empty of the FIFO, overrides push/pop
//   clr_i     synchronous clear of the sticky error flags
//   wen_o     register-file write enable (combinational)
//   waddr_o   register-file write address (write pointer)
//   raddr_o   register-file read address (read pointer)
//   full_o    occupancy == 8 (registered)
//   empty_o   occupancy == 0 (registered)
//   count_o   occupancy 0..8 (registered)
//   ovf_o     sticky overflow flag
//   udf_o     sticky underflow flag
//   afull_o   almost-full indication
//
// Build option
//   FIFO_CTRL8_AFULL_EN  when defined, afull_o is a registered (count >= AF_LVL);
//                        when undefined, afull_o is tied low and no threshold
//                        logic exists.
// -----------------------------------------------------------------------------
module fifo_ctrl8 #(
    parameter int DW     = 8,
    parameter int AF_LVL = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  logic       clr_i,
    output logic       wen_o,
    output logic [2:0] waddr_o,
    output logic [2:0] raddr_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [3:0] count_o,
    output logic       ovf_o,
    output logic       udf_o,
    output logic       afull_o
);

    // Elaboration-time parameter sanity checks.
    if (DW < 1) begin : g_dw_chk
        $error("fifo_ctrl8: DW must be at least 1");
    end
    if (AF_LVL < 1 || AF_LVL > 8) begin : g_af_lvl_chk
        $error("fifo_ctrl8: AF_LVL must be in 1..8");
    end

    logic [2:0] wptr_q, wptr_d;
    logic [2:0] rptr_q, rptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;

    logic       push_acc;
    logic       pop_acc;
    logic       ovf_evt;
    logic       udf_evt;

    // A push into a full FIFO is only legal when the head is consumed in the
    // same cycle; a full FIFO is never empty, so pop_i alone implies an
    // accepted pop there. Flush masks everything, including error events.
    always_comb begin
        push_acc = push_i & ~flush_i & (~full_q | pop_i);
        pop_acc  = pop_i  & ~flush_i & ~empty_q;
        ovf_evt  = push_i & ~flush_i &  full_q & ~pop_i;
        udf_evt  = pop_i  & ~flush_i &  empty_q;
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = 3'd0;
            rptr_d = 3'd0;
            cnt_d  = 4'd0;
        end else begin
            // 3-bit pointers wrap 7 -> 0 naturally.
            if (push_acc) wptr_d = wptr_q + 3'd1;
            if (pop_acc)  rptr_d = rptr_q + 3'd1;
            case ({push_acc, pop_acc})
                2'b10:   cnt_d = cnt_q + 4'd1;
                2'b01:   cnt_d = cnt_q - 4'd1;
                default: cnt_d = cnt_q;
            endcase
        end
        // Flags are derived from the next count so they line up with count_o.
        full_d  = (cnt_d == 4'd8);
        empty_d = (cnt_d == 4'd0);
        // Set wins over clear when both happen in the same cycle.
        ovf_d   = ovf_evt | (ovf_q & ~clr_i);
        udf_d   = udf_evt | (udf_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            cnt_q   <= 4'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef FIFO_CTRL8_AFULL_EN
    logic afull_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= (cnt_d >= 4'(AF_LVL));
        end
    end

    assign afull_o = afull_q;
`else
    assign afull_o = 1'b0;
`endif

    assign wen_o   = push_acc;
    assign waddr_o = wptr_q;
    assign raddr_o = rptr_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

endmodule

// File: tb/tb_fifo_ctrl8.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl8 -- table-driven bench for fifo_ctrl8 with a slot scoreboard:
// every accepted push records its write slot, every accepted pop must present
// the oldest recorded slot on raddr_o.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_i, pop_i, flush_i, clr_i;
    logic       wen_o;
    logic [2:0] waddr_o, raddr_o;
    logic       full_o, empty_o;
    logic [3:0] count_o;
    logic       ovf_o, udf_o, afull_o;

    fifo_ctrl8 #(.DW(8), .AF_LVL(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_i),
        .pop_i   (pop_i),
        .flush_i (flush_i),
        .clr_i   (clr_i),
        .wen_o   (wen_o),
        .waddr_o (waddr_o),
        .raddr_o (raddr_o),
        .full_o  (full_o),
        .empty_o (empty_o),
        .count_o (count_o),
        .ovf_o   (ovf_o),
        .udf_o   (udf_o),
        .afull_o (afull_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, flush, clr;
        logic       wen;   // expected wen_o before the edge
        logic       rd;    // pop expected to be accepted at the edge
        logic [3:0] cnt;   // expected state after the edge
        logic [2:0] wa, ra;
        logic       ovf, udf;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb_q[$];
    logic [2:0] exp_w;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_afull(input logic [3:0] cnt);
`ifdef FIFO_CTRL8_AFULL_EN
        return (cnt >= 4'd6);
`else
        return (cnt != cnt);
`endif
    endfunction

    task automatic add(input logic p, po, f, c, w, r, input int cnt, wa, ra,
                       input logic ov, ud);
        vec_t v;
        v.push = p; v.pop = po; v.flush = f; v.clr = c;
        v.wen = w; v.rd = r; v.cnt = 4'(cnt); v.wa = 3'(wa); v.ra = 3'(ra);
        v.ovf = ov; v.udf = ud;
        vecs.push_back(v);
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic [2:0] wa,
                             input logic [2:0] ra, input logic ov, input logic ud);
        chk({tag, " count"}, count_o, cnt);
        chk({tag, " full"},  full_o,  (cnt == 4'd8));
        chk({tag, " empty"}, empty_o, (cnt == 4'd0));
        chk({tag, " waddr"}, waddr_o, wa);
        chk({tag, " raddr"}, raddr_o, ra);
        chk({tag, " ovf"},   ovf_o,   ov);
        chk({tag, " udf"},   udf_o,   ud);
        chk({tag, " afull"}, afull_o, exp_afull(cnt));
    endtask

    initial begin
        rst_n = 1'b0; push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clr_i = 1'b0;
        exp_w = 3'd0;

        // fill: 8 pushes
        for (int i = 1; i <= 8; i++) add(1, 0, 0, 0, 1, 0, i, i % 8, 0, 0, 0);
        // full with push and pop together
        add(1, 1, 0, 0, 1, 1, 8, 1, 1, 0, 0);
        // ninth push without pop: dropped, overflow
        add(1, 0, 0, 0, 0, 0, 8, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 8, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 8, 1, 1, 0, 0);
        // drain: 8 pops, read pointer wraps
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, 0, 1, 8 - i, 1, (1 + i) % 8, 0, 0);
        // pop when empty with simultaneous push
        add(1, 1, 0, 0, 1, 0, 1, 2, 1, 0, 1);
        // pop with clear, then underflow coinciding with clear, then clear
        add(0, 1, 0, 1, 0, 1, 0, 2, 2, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 2, 2, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 2, 2, 0, 0);
        // flush with push at count 3, then flush with pop at empty
        for (int i = 1; i <= 3; i++) add(1, 0, 0, 0, 1, 0, i, 2 + i, 2, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // wrap-around: 5 pushes, 5 pops, 6 pushes
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 1, 0, i, i, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, 0, 1, 5 - i, 5, i, 0, 0);
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 0, 1, 0, i, (5 + i) % 8, 5, 0, 0);

        #12;
        chk_state("reset", 4'd0, 3'd0, 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            push_i = vecs[i].push; pop_i = vecs[i].pop;
            flush_i = vecs[i].flush; clr_i = vecs[i].clr;
            #1;
            chk({tag, " wen"}, wen_o, vecs[i].wen);
            if (vecs[i].rd) begin
                if (sb_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL %s scoreboard: pop with no recorded slot", tag);
                end else begin
                    chk({tag, " sb raddr"}, raddr_o, sb_q.pop_front());
                end
            end
            if (vecs[i].wen) begin
                chk({tag, " sb waddr"}, waddr_o, exp_w);
                sb_q.push_back(exp_w);
            end
            if (vecs[i].flush) sb_q.delete();
            @(posedge clk);
            #1;
            chk_state(tag, vecs[i].cnt, vecs[i].wa, vecs[i].ra, vecs[i].ovf, vecs[i].udf);
            exp_w = vecs[i].wa;
            @(negedge clk);
        end

        // asynchronous reset in the middle of a push burst, away from any edge
        push_i = 1'b1; pop_i = 1'b0; flush_i = 1'b0; clr_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 4'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        sb_q.delete();
        @(posedge clk);
        #1;
        chk_state("rst_hold", 4'd0, 3'd0, 3'd0, 1'b0, 1'b0);

        // first operation accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        push_i = 1'b1;
        #1;
        chk("rel wen", wen_o, 1'b1);
        @(posedge clk);
        #1;
        chk_state("rel", 4'd1, 3'd1, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        push_i = 1'b0;
        @(posedge clk);
        #1;
        chk_state("rel_idle", 4'd1, 3'd1, 3'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl8.md
FIFO_CTRL8 -- requirements
Module: fifo_ctrl8

Interface
REQ-001 SHALL provide parameter DW, default 8: data width of the attached 8-entry register file (pass-through documentation only; no data path in this block).
REQ-002 SHALL provide parameter AF_LVL, default 6: almost-full threshold in entries, legal range 1..8.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 push_i  input  1  write request; data presented to the register file in the same cycle.
REQ-007 pop_i  input  1  read request; head entry consumed at this edge.
REQ-008 flush_i  input  1  synchronous empty of the FIFO.
REQ-009 clr_i  input  1  synchronous clear of sticky error flags.
REQ-010 wen_o  output  1  register-file write enable (combinational).
REQ-011 waddr_o  output  3  register-file write address = write pointer.
REQ-012 raddr_o  output  3  register-file read address = read pointer; read data is valid in the same cycle.
REQ-013 full_o  output  1  count == 8.
REQ-014 empty_o  output  1  count == 0.
REQ-015 count_o  output  4  occupancy, 0..8.
REQ-016 ovf_o  output  1  sticky overflow flag.
REQ-017 udf_o  output  1  sticky underflow flag.
REQ-018 afull_o  output  1  almost-full indication.

Function
REQ-019 Accepted push SHALL be: push_i & ~flush_i & (~full_o | pop_i).
REQ-020 Accepted pop SHALL be: pop_i & ~flush_i & ~empty_o.
REQ-021 wen_o SHALL equal accepted push, combinationally, in the same cycle.
REQ-022 Write pointer SHALL increment by one on each accepted push and wrap from 7 to 0.
REQ-023 Read pointer SHALL increment by one on each accepted pop and wrap from 7 to 0.
REQ-024 count_o SHALL change as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 full_o, empty_o and count_o SHALL be registered outputs, consistent with count after each edge.
REQ-026 Push while full SHALL be accepted only when an accepted pop occurs in the same cycle; count stays 8.
REQ-027 Push while full without pop SHALL be dropped: wen_o=0, pointers unchanged, ovf_o set at the next edge.
REQ-028 Pop while empty SHALL be ignored and set udf_o at the next edge; a simultaneous push is still accepted.
REQ-029 flush_i SHALL, at the next edge, set both pointers to 0 and count to 0; it overrides push/pop, which set no error flags.
REQ-030 ovf_o and udf_o SHALL hold until clr_i; if an error event and clr_i coincide, the flag SHALL be set.
REQ-031 The write and read paths SHALL have zero-cycle latency; a push is visible at the head one edge after acceptance.

Reset
REQ-032 rst_n low SHALL asynchronously force: pointers 0, count_o 0, empty_o 1, full_o 0, ovf_o 0, udf_o 0, afull_o 0.
REQ-033 Reset mid-operation SHALL discard all contents without completing any in-flight push or pop.
REQ-034 Reset release SHALL be synchronous to clk; the first operation SHALL be accepted on the first edge after release.

Configuration
REQ-035 With macro FIFO_CTRL8_AFULL_EN defined, afull_o SHALL be a registered output equal to (count >= AF_LVL).
REQ-036 Without FIFO_CTRL8_AFULL_EN, afull_o SHALL be tied to 0, and no threshold logic SHALL be synthesised.

Verification
REQ-037 Fill then drain: 8 pushes -> waddr_o 0..7, full_o=1, count_o=8; 8 pops -> raddr_o 0..7, empty_o=1.
REQ-038 Full with push and pop together: count 8 -> wen_o=1, count stays 8, both pointers advance; ovf_o stays 0.
REQ-039 Ninth push without pop -> wen_o=0, ovf_o=1, held across 5 idle cycles, cleared one edge after clr_i.
REQ-040 Pop when empty, with simultaneous push -> udf_o=1, count_o=1, waddr_o advances to 1.
REQ-041 Wrap-around: 5 pushes, 5 pops, 6 pushes -> waddr_o wraps 7->0, count_o=6; with FIFO_CTRL8_AFULL_EN and AF_LVL=6, afull_o=1.
REQ-042 Reset and flush: flush_i with push_i at count 3 -> count 0, pointers 0; rst_n pulsed mid-burst -> all REQ-032 values asynchronously.
